jtlabrun_vtimer: RTL and testbench
==================================

Name: jtlabrun_vtimer

Overview:
Video timing and interrupt generator for the Labyrinth Runner core. It generates the H/V counters, sync and blanking signals, and the CPU interrupt lines gfx_irqn and gfx_nmin that the main CPU block consumes. It contains a small CPU-writable control/status register set, decoded by the main CPU block from its config window. It runs on the 24 MHz system clock with a 6 MHz pixel clock enable.

Parameters:
HTOTAL, 384, pixel clocks per line; hdump counts 0..HTOTAL-1
VTOTAL, 264, lines per frame; vdump counts 0..VTOTAL-1
HB_START, 256, first hdump of horizontal blank
VB_START, 240, first vdump of vertical blank; this line also sets the IRQ
VB_END, 16, first visible vdump
NMI_LEN, 16, length of the NMI low pulse in pixel clocks

Ports:
clk  in  1  24 MHz system clock
rst  in  1  synchronous, active-high reset
pxl_cen  in  1  6 MHz pixel clock enable
cpu_cen  in  1  CPU bus clock enable; register writes are accepted only on this enable
cs  in  1  register window select
addr  in  1  register index
rnw  in  1  1 = read, 0 = write
din  in  8  CPU write data
dout  out  8  register read data
hdump  out  9  horizontal counter
vdump  out  9  vertical counter
flip  out  1  screen flip bit
LHBL  out  1  horizontal blank, active low
LVBL  out  1  vertical blank, active low
HS  out  1  horizontal sync, active high
VS  out  1  vertical sync, active high
irqn  out  1  vblank IRQ, active low, level
nmin  out  1  periodic NMI, active low, pulse

Behaviour:
- Reset values: hdump=0, vdump=0, LHBL=0, LVBL=0, HS=0, VS=0, irqn=1, nmin=1, ctrl=0, flip=0, dout=0.
- Counters
  - All counter and timing updates occur only on pxl_cen.
  - hdump wraps from HTOTAL-1 to 0.
  - vdump increments when hdump wraps, and itself wraps from VTOTAL-1 to 0.
- Blanking and sync (registered; each value takes effect on the same pxl_cen on which the counter changes)
  - LHBL = 1 for hdump < HB_START.
  - LVBL = 1 for VB_END <= vdump < VB_START.
  - HS = 1 for hdump 296..327.
  - VS = 1 for vdump 248..255.
- Control register, write addr 0, rnw=0, cs=1, on cpu_cen:
  - bit0 irq_en
  - bit1 nmi_en
  - bit3 flip
  - other bits are ignored and read back as 0.
- IRQ
  - At the pxl_cen where vdump becomes VB_START with hdump=0: if irq_en=1, irqn goes 0.
  - irqn stays 0 until a write with bit0=0, which is also the acknowledge. irqn returns to 1 on the cpu_cen of that write.
  - If the clearing write and the set event fall in the same clk cycle, the clear wins and irqn=1.
  - Writing bit0=1 while irqn=0 keeps irqn at 0.
- NMI
  - When nmi_en=1 and hdump=0 on a line with vdump[4:0]=0, nmin goes 0 for exactly NMI_LEN pxl_cen ticks, then returns to 1.
  - Clearing nmi_en mid-pulse forces nmin=1 on the next clk.
- Status register, read addr 1:
  - {5'b0, irq pending (~irqn), ~LVBL, LVBL}.
  - Read addr 0 returns ctrl.
  - dout is registered, with 1-clk latency after cs/addr.
- Reset mid-frame: all state returns to reset values within the same clk cycle. Counting restarts at 0,0.
- Register writes take effect regardless of pxl_cen.

Decomposition:
- Shared package:
  - timing constants (HTOTAL, VTOTAL, HB_START, VB_START, VB_END, HS_START=296, HS_END=327, VS_START=248, VS_END=255)
  - control bit indices (CTRL_IRQEN=0, CTRL_NMIEN=1, CTRL_FLIP=3).
- One sub-module: jtlabrun_vcnt. It holds the H/V counters and the blank/sync decode.
- The top level adds the registers and the IRQ/NMI logic.

Test Plan:
- Reset, then run 2 frames with pxl_cen every 4th clk -> hdump period 384, vdump period 264; LVBL low exactly for vdump 240..263 and 0..15; HS high for hdump 296..327.
- ctrl=0x01, run to vdump=240/hdump=0 -> irqn=0 on that pxl_cen; write 0x00 -> irqn=1 on that cpu_cen; status read before the ack returns 0x06, after the ack returns 0x02.
- Clearing write timed on the exact vdump=240/hdump=0 clk -> irqn stays 1.
- ctrl=0x02 -> nmin low for 16 pxl_cen at lines 0, 32, 64, …, 256 (9 pulses per frame); clearing nmi_en at pulse tick 5 -> nmin=1 on the next clk.
- ctrl=0x09 -> flip=1, read addr0 returns 0x09; write 0xFF -> read returns 0x0B.
- Assert rst at vdump=100 with irqn=0 -> all outputs at reset values the next clk; count resumes from 0,0.

Source files
------------

// File: rtl/jtlabrun_vtimer_pkg.sv
// Shared timing constants and control-register bit layout for the
// Labyrinth Runner video timer.
package jtlabrun_vtimer_pkg;

  localparam int unsigned HTOTAL   = 384;
  localparam int unsigned VTOTAL   = 264;
  localparam int unsigned HB_START = 256;
  localparam int unsigned VB_START = 240;
  localparam int unsigned VB_END   = 16;
  localparam int unsigned HS_START = 296;
  localparam int unsigned HS_END   = 327;
  localparam int unsigned VS_START = 248;
  localparam int unsigned VS_END   = 255;
  localparam int unsigned NMI_LEN  = 16;

  localparam int unsigned CTRL_IRQEN = 0;
  localparam int unsigned CTRL_NMIEN = 1;
  localparam int unsigned CTRL_FLIP  = 3;

  // Bits of the control register that exist; everything else reads as 0.
  localparam logic [7:0] CTRL_MASK =
    8'((1 << CTRL_IRQEN) | (1 << CTRL_NMIEN) | (1 << CTRL_FLIP));

  typedef enum logic {
    REG_CTRL   = 1'b0,
    REG_STATUS = 1'b1
  } reg_idx_e;

endpackage

// File: rtl/jtlabrun_vcnt.sv
// H/V pixel counters with registered blanking and sync decode.
module jtlabrun_vcnt
  import jtlabrun_vtimer_pkg::*;
#(
  parameter int unsigned HTOTAL   = jtlabrun_vtimer_pkg::HTOTAL,
  parameter int unsigned VTOTAL   = jtlabrun_vtimer_pkg::VTOTAL,
  parameter int unsigned HB_START = jtlabrun_vtimer_pkg::HB_START,
  parameter int unsigned VB_START = jtlabrun_vtimer_pkg::VB_START,
  parameter int unsigned VB_END   = jtlabrun_vtimer_pkg::VB_END,
  parameter int unsigned HS_START = jtlabrun_vtimer_pkg::HS_START,
  parameter int unsigned HS_END   = jtlabrun_vtimer_pkg::HS_END,
  parameter int unsigned VS_START = jtlabrun_vtimer_pkg::VS_START,
  parameter int unsigned VS_END   = jtlabrun_vtimer_pkg::VS_END
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  output logic [8:0] hdump,
  output logic [8:0] vdump,
  output logic [8:0] hnext,
  output logic [8:0] vnext,
  output logic       LHBL,
  output logic       LVBL,
  output logic       HS,
  output logic       VS
);

  localparam logic [8:0] H_LAST = 9'(HTOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(VTOTAL - 1);

  always_comb begin
    hnext = (hdump == H_LAST) ? '0 : hdump + 9'd1;
    vnext = vdump;
    if (hdump == H_LAST)
      vnext = (vdump == V_LAST) ? '0 : vdump + 9'd1;
  end

  // Decode from the next counter values so flags move with the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdump <= '0;
      vdump <= '0;
      LHBL  <= 1'b0;
      LVBL  <= 1'b0;
      HS    <= 1'b0;
      VS    <= 1'b0;
    end else if (pxl_cen) begin
      hdump <= hnext;
      vdump <= vnext;
      LHBL  <= hnext < 9'(HB_START);
      LVBL  <= (vnext >= 9'(VB_END)) && (vnext < 9'(VB_START));
      HS    <= (hnext >= 9'(HS_START)) && (hnext <= 9'(HS_END));
      VS    <= (vnext >= 9'(VS_START)) && (vnext <= 9'(VS_END));
    end
  end

endmodule

// File: rtl/jtlabrun_vtimer.sv
// Video timer top: counters, CPU control/status registers, vblank IRQ and
// periodic NMI generation.
module jtlabrun_vtimer
  import jtlabrun_vtimer_pkg::*;
#(
  parameter int unsigned HTOTAL   = jtlabrun_vtimer_pkg::HTOTAL,
  parameter int unsigned VTOTAL   = jtlabrun_vtimer_pkg::VTOTAL,
  parameter int unsigned HB_START = jtlabrun_vtimer_pkg::HB_START,
  parameter int unsigned VB_START = jtlabrun_vtimer_pkg::VB_START,
  parameter int unsigned VB_END   = jtlabrun_vtimer_pkg::VB_END,
  parameter int unsigned HS_START = jtlabrun_vtimer_pkg::HS_START,
  parameter int unsigned HS_END   = jtlabrun_vtimer_pkg::HS_END,
  parameter int unsigned VS_START = jtlabrun_vtimer_pkg::VS_START,
  parameter int unsigned VS_END   = jtlabrun_vtimer_pkg::VS_END,
  parameter int unsigned NMI_LEN  = jtlabrun_vtimer_pkg::NMI_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       cpu_cen,
  input  logic       cs,
  input  logic       addr,
  input  logic       rnw,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [8:0] hdump,
  output logic [8:0] vdump,
  output logic       flip,
  output logic       LHBL,
  output logic       LVBL,
  output logic       HS,
  output logic       VS,
  output logic       irqn,
  output logic       nmin
);

  localparam int unsigned NW = (NMI_LEN > 1) ? $clog2(NMI_LEN) : 1;

  logic [8:0]    hnext;
  logic [8:0]    vnext;
  logic [7:0]    ctrl;
  logic [7:0]    ctrl_nx;
  logic          wr;
  logic          irq_set;
  logic          nmi_trig;
  logic [NW-1:0] nmi_cnt;

  jtlabrun_vcnt #(
    .HTOTAL  (HTOTAL),
    .VTOTAL  (VTOTAL),
    .HB_START(HB_START),
    .VB_START(VB_START),
    .VB_END  (VB_END),
    .HS_START(HS_START),
    .HS_END  (HS_END),
    .VS_START(VS_START),
    .VS_END  (VS_END)
  ) u_vcnt (
    .clk    (clk),
    .rst    (rst),
    .pxl_cen(pxl_cen),
    .hdump  (hdump),
    .vdump  (vdump),
    .hnext  (hnext),
    .vnext  (vnext),
    .LHBL   (LHBL),
    .LVBL   (LVBL),
    .HS     (HS),
    .VS     (VS)
  );

  always_comb begin
    wr       = cpu_cen && cs && !rnw && (reg_idx_e'(addr) == REG_CTRL);
    ctrl_nx  = wr ? (din & CTRL_MASK) : ctrl;
    irq_set  = pxl_cen && (hnext == '0) && (vnext == 9'(VB_START));
    nmi_trig = pxl_cen && (hnext == '0) && (vnext[4:0] == '0);
  end

  assign flip = ctrl[CTRL_FLIP];

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl    <= '0;
      irqn    <= 1'b1;
      nmin    <= 1'b1;
      nmi_cnt <= '0;
      dout    <= '0;
    end else begin
      ctrl <= ctrl_nx;

      // The acknowledge write wins over a simultaneous vblank set.
      if (wr && !din[CTRL_IRQEN])
        irqn <= 1'b1;
      else if (irq_set && ctrl[CTRL_IRQEN])
        irqn <= 1'b0;

      // nmi_cnt holds remaining low ticks minus one while nmin is low.
      if (!ctrl_nx[CTRL_NMIEN]) begin
        nmin    <= 1'b1;
        nmi_cnt <= '0;
      end else if (pxl_cen) begin
        if (nmi_trig) begin
          nmin    <= 1'b0;
          nmi_cnt <= NW'(NMI_LEN - 1);
        end else if (!nmin) begin
          if (nmi_cnt == '0)
            nmin <= 1'b1;
          else
            nmi_cnt <= nmi_cnt - 1'b1;
        end
      end

      if (cs && rnw)
        dout <= (reg_idx_e'(addr) == REG_STATUS) ? {5'b0, ~irqn, ~LVBL, LVBL} : ctrl;
    end
  end

endmodule

// File: tb/tb_jtlabrun_vtimer.sv
// Directed bench for jtlabrun_vtimer on a shrunken raster geometry, with a
// raster-level reference model compared on every clock.
module tb_jtlabrun_vtimer;

  localparam int unsigned HT  = 24;
  localparam int unsigned VT  = 72;
  localparam int unsigned HB  = 16;
  localparam int unsigned VBS = 60;
  localparam int unsigned VBE = 4;
  localparam int unsigned HSS = 18;
  localparam int unsigned HSE = 20;
  localparam int unsigned VSS = 62;
  localparam int unsigned VSE = 63;
  localparam int unsigned NL  = 16;
  localparam int unsigned LIM = 2 * HT * VT + 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       cpu_cen = 1'b0;
  logic       cs = 1'b0;
  logic       addr = 1'b0;
  logic       rnw = 1'b1;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic [8:0] hdump, vdump;
  logic       flip, LHBL, LVBL, HS, VS, irqn, nmin;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pcnt = 0;
  bit          chk_on = 1'b0;

  // reference model state
  int unsigned m_h, m_v, m_rem;
  logic        m_lhbl, m_lvbl, m_hs, m_vs, m_irqn, m_nmin;
  logic [7:0]  m_ctrl, m_dout;

  jtlabrun_vtimer #(
    .HTOTAL(HT), .VTOTAL(VT), .HB_START(HB), .VB_START(VBS), .VB_END(VBE),
    .HS_START(HSS), .HS_END(HSE), .VS_START(VSS), .VS_END(VSE), .NMI_LEN(NL)
  ) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cpu_cen(cpu_cen), .cs(cs),
    .addr(addr), .rnw(rnw), .din(din), .dout(dout), .hdump(hdump),
    .vdump(vdump), .flip(flip), .LHBL(LHBL), .LVBL(LVBL), .HS(HS), .VS(VS),
    .irqn(irqn), .nmin(nmin)
  );

  initial forever #5 clk = ~clk;

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin : model
    int unsigned hn, vn, rn;
    logic [7:0]  cn;
    logic        w;
    if (rst) begin
      m_h <= 0; m_v <= 0; m_rem <= 0;
      m_lhbl <= 1'b0; m_lvbl <= 1'b0; m_hs <= 1'b0; m_vs <= 1'b0;
      m_irqn <= 1'b1; m_nmin <= 1'b1; m_ctrl <= '0; m_dout <= '0;
    end else begin
      w  = cpu_cen && cs && !rnw && !addr;
      cn = w ? (din & 8'h0B) : m_ctrl;
      hn = m_h; vn = m_v; rn = m_rem;
      if (pxl_cen) begin
        hn = (m_h + 1) % HT;
        if (hn == 0) vn = (m_v + 1) % VT;
        m_lhbl <= hn < HB;
        m_lvbl <= vn >= VBE && vn < VBS;
        m_hs   <= hn >= HSS && hn <= HSE;
        m_vs   <= vn >= VSS && vn <= VSE;
      end
      m_h <= hn; m_v <= vn; m_ctrl <= cn;
      if (w && !din[0])
        m_irqn <= 1'b1;
      else if (pxl_cen && hn == 0 && vn == VBS && m_ctrl[0])
        m_irqn <= 1'b0;
      if (!cn[1]) rn = 0;
      else if (pxl_cen) begin
        if (hn == 0 && vn % 32 == 0) rn = NL;
        else if (rn > 0) rn = rn - 1;
      end
      m_rem  <= rn;
      m_nmin <= (rn == 0);
      if (cs && rnw)
        m_dout <= addr ? {5'b0, ~m_irqn, ~m_lvbl, m_lvbl} : m_ctrl;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("hdump", 16'(hdump), 16'(m_h));
      check("vdump", 16'(vdump), 16'(m_v));
      check("LHBL",  16'(LHBL),  16'(m_lhbl));
      check("LVBL",  16'(LVBL),  16'(m_lvbl));
      check("HS",    16'(HS),    16'(m_hs));
      check("VS",    16'(VS),    16'(m_vs));
      check("irqn",  16'(irqn),  16'(m_irqn));
      check("nmin",  16'(nmin),  16'(m_nmin));
      check("flip",  16'(flip),  16'(m_ctrl[3]));
      check("dout",  16'(dout),  16'(m_dout));
    end
  end

  task automatic cyc();
    @(negedge clk);
    pxl_cen = (pcnt == 3);
    pcnt = (pcnt + 1) % 4;
  endtask

  // advance to the negedge just after the next pixel tick
  task automatic pxl_step();
    int unsigned n = 0;
    do begin cyc(); n++; end while (!pxl_cen && n < 8);
    cyc();
  endtask

  task automatic write(input logic [7:0] d);
    cs = 1'b1; rnw = 1'b0; addr = 1'b0; cpu_cen = 1'b1; din = d;
    cyc();
    cs = 1'b0; rnw = 1'b1; cpu_cen = 1'b0;
  endtask

  task automatic read(input logic a, input logic [7:0] exp, input string name);
    cs = 1'b1; rnw = 1'b1; addr = a;
    cyc();
    cs = 1'b0;
    check(name, 16'(dout), 16'(exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hdump"}, 16'(hdump), 16'd0);
    check({tag, "_vdump"}, 16'(vdump), 16'd0);
    check({tag, "_LHBL"},  16'(LHBL),  16'd0);
    check({tag, "_LVBL"},  16'(LVBL),  16'd0);
    check({tag, "_HS"},    16'(HS),    16'd0);
    check({tag, "_VS"},    16'(VS),    16'd0);
    check({tag, "_irqn"},  16'(irqn),  16'd1);
    check({tag, "_nmin"},  16'(nmin),  16'd1);
    check({tag, "_flip"},  16'(flip),  16'd0);
    check({tag, "_dout"},  16'(dout),  16'd0);
  endtask

  initial begin
    int unsigned lvbl_lo, hs_hi, vs_hi, nmi_lo, nmi_falls, hmax, vmax, n;
    logic        prev_nmin;

    repeat (3) cyc();
    chk_on = 1'b1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // two full frames from 0,0
    lvbl_lo = 0; hs_hi = 0; vs_hi = 0; hmax = 0; vmax = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      pxl_step();
      if (!LVBL) lvbl_lo++;
      if (HS) hs_hi++;
      if (VS) vs_hi++;
      if (hdump > hmax) hmax = hdump;
      if (vdump > vmax) vmax = vdump;
    end
    check("frame_wrap_h", 16'(hdump), 16'd0);
    check("frame_wrap_v", 16'(vdump), 16'd0);
    check("hdump_max", 16'(hmax), 16'd23);
    check("vdump_max", 16'(vmax), 16'd71);
    check("lvbl_low_ticks", 16'(lvbl_lo), 16'd768);  // 16 lines * 24 * 2
    check("hs_high_ticks",  16'(hs_hi),   16'd432);  // 3 * 72 * 2
    check("vs_high_ticks",  16'(vs_hi),   16'd96);   // 2 lines * 24 * 2

    // vblank IRQ, status and acknowledge
    write(8'h01);
    n = 0;
    while (!(m_v == VBS && m_h == 0) && n < LIM) begin pxl_step(); n++; end
    check("irq_wait_timeout", 16'(n < LIM), 16'd1);
    check("irq_set_irqn", 16'(irqn), 16'd0);
    read(1'b1, 8'h06, "status_pending");
    write(8'h00);
    check("irq_ack_irqn", 16'(irqn), 16'd1);
    read(1'b1, 8'h02, "status_acked");

    // acknowledge landing on the exact set clock
    write(8'h01);
    n = 0;
    forever begin
      cyc(); n++;
      if ((pxl_cen && m_h == HT - 1 && m_v == VBS - 1) || n >= 4 * LIM) break;
    end
    check("race_wait_timeout", 16'(n < 4 * LIM), 16'd1);
    write(8'h00);
    check("race_hdump", 16'(hdump), 16'd0);
    check("race_vdump", 16'(vdump), 16'(VBS));
    check("race_irqn", 16'(irqn), 16'd1);
    for (int i = 0; i < 4; i++) pxl_step();
    check("race_irqn_hold", 16'(irqn), 16'd1);

    // periodic NMI over one frame
    write(8'h02);
    n = 0;
    while (!(m_v == 1 && m_h == 0) && n < LIM) begin pxl_step(); n++; end
    check("nmi_align_timeout", 16'(n < LIM), 16'd1);
    nmi_lo = 0; nmi_falls = 0; prev_nmin = nmin;
    for (int i = 0; i < HT * VT; i++) begin
      pxl_step();
      if (!nmin) nmi_lo++;
      if (prev_nmin && !nmin) nmi_falls++;
      prev_nmin = nmin;
    end
    check("nmi_pulses", 16'(nmi_falls), 16'd3);   // lines 32, 64, 0
    check("nmi_low_ticks", 16'(nmi_lo), 16'd48);

    // clear nmi_en at pulse tick 5
    n = 0;
    while (m_nmin && n < LIM) begin pxl_step(); n++; end
    check("nmi_start_timeout", 16'(n < LIM), 16'd1);
    for (int i = 0; i < 4; i++) pxl_step();
    check("nmi_mid_low", 16'(nmin), 16'd0);
    write(8'h00);
    check("nmi_cleared", 16'(nmin), 16'd1);

    // flip and masked control readback
    write(8'h09);
    check("flip_set", 16'(flip), 16'd1);
    read(1'b0, 8'h09, "ctrl_read_09");
    write(8'hFF);
    read(1'b0, 8'h0B, "ctrl_read_ff");

    // reset mid-frame with IRQ pending
    n = 0;
    while (!(m_v == VBS - 1) && n < LIM) begin pxl_step(); n++; end
    while (!(m_v == VBS + 5 && m_h == 5) && n < LIM) begin pxl_step(); n++; end
    check("rst_wait_timeout", 16'(n < LIM), 16'd1);
    check("pre_rst_irqn", 16'(irqn), 16'd0);
    rst = 1'b1;
    cyc();
    check_reset_outputs("midrst");
    rst = 1'b0;
    pxl_step();
    check("resume_hdump", 16'(hdump), 16'd1);
    check("resume_vdump", 16'(vdump), 16'd0);

    repeat (4) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
